// File: rtl/img_row_loader.sv
// img_row_loader: packs the 16-bit host pixel stream into full image rows and writes each row to the image SRAM.
// Optional feature: define LOADER_CHECKSUM_EN to add a modulo-2^16 frame checksum output.
module img_row_loader #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int IN_W   = 16,
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   img_we,
    output logic [ADDR_W-1:0]      img_addr,
    output logic [IMG_W*PIX_W-1:0] img_din,
    output logic                   busy,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]            checksum,
`endif
    output logic                   done
);

    localparam int ROW_W = IMG_W * PIX_W;
    localparam int WPR   = ROW_W / IN_W;
    localparam int W_W   = 9;
    localparam int OFS_W = $clog2(ROW_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [W_W-1:0]      w_q, w_d;
    logic [ADDR_W-1:0]   r_q, r_d;
    logic [ROW_W-1:0]    asm_q, asm_d;
    logic [ROW_W-1:0]    din_q, din_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_q, last_d;
    logic [OFS_W-1:0]    ofs_s;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]         cks_q, cks_d;
`endif

    // Next-state logic: word capture, row hand-off to the output register and frame sequencing
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        asm_d   = asm_q;
        din_d   = din_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_d  = last_q;
        ofs_s   = OFS_W'(w_q) * OFS_W'(IN_W);
`ifdef LOADER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d            = ST_LOAD;
                    busy_d             = 1'b1;
                    r_d                = {ADDR_W{1'b0}};
                    w_d                = 9'd1;
                    asm_d[IN_W-1:0]    = in_data;
`ifdef LOADER_CHECKSUM_EN
                    cks_d              = 16'(in_data);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // last_q marks the write cycle of the final row; input is ignored until IDLE
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    w_d     = {W_W{1'b0}};
                    r_d     = {ADDR_W{1'b0}};
                end else if (in_valid) begin
                    asm_d[ofs_s +: IN_W] = in_data;
`ifdef LOADER_CHECKSUM_EN
                    cks_d = cks_q + 16'(in_data);
`endif
                    if (w_q == W_W'(WPR - 1)) begin
                        w_d    = {W_W{1'b0}};
                        din_d  = asm_d;
                        addr_d = r_q;
                        we_d   = 1'b1;
                        if (r_q == ADDR_W'(IMG_H - 1)) begin
                            last_d = 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        w_d = w_q + 1'b1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= {W_W{1'b0}};
            r_q     <= {ADDR_W{1'b0}};
            asm_q   <= {ROW_W{1'b0}};
            din_q   <= {ROW_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            r_q     <= r_d;
            asm_q   <= asm_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    assign img_we   = we_q;
    assign img_addr = addr_q;
    assign img_din  = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_img_row_loader.sv
// tb_img_row_loader: randomized frames checked against a pixel-level reference model of the row loader.
// Uses a reduced image height so several complete frames fit in a short run.
module tb_img_row_loader;

    localparam int IMG_W  = 640;
    localparam int IMG_H  = 4;
    localparam int PIX_W  = 8;
    localparam int IN_W   = 16;
    localparam int ADDR_W = 9;
    localparam int WPR    = IMG_W * PIX_W / IN_W;
    localparam int ROW_W  = IMG_W * PIX_W;
    localparam int NWORDS = WPR * IMG_H;

    typedef logic [ROW_W-1:0] wide_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [IN_W-1:0]     in_data;
    logic                img_we;
    logic [ADDR_W-1:0]   img_addr;
    logic [ROW_W-1:0]    img_din;
    logic                busy;
    logic                done;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]         checksum;
`endif

    img_row_loader #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .IN_W  (IN_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .img_we  (img_we),
        .img_addr(img_addr),
        .img_din (img_din),
        .busy    (busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed SRAM writes and done pulses
    int                  we_cyc[$];
    logic [ADDR_W-1:0]   we_addr[$];
    wide_t               we_din[$];
    logic                we_busy[$];
    int                  done_cyc[$];
    logic                done_busy[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (img_we) begin
                we_cyc.push_back(cyc);
                we_addr.push_back(img_addr);
                we_din.push_back(img_din);
                we_busy.push_back(busy);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(busy);
            end
        end
    end

    // Reference data: frame words and the clock edge capturing each row's last word
    logic [IN_W-1:0] fw[NWORDS];
    int              row_edge[IMG_H];

    task automatic check_val(input string tag, input wide_t got, input wide_t exp);
        int k;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            k = 0;
            for (int i = ROW_W/32 - 1; i >= 0; i--)
                if (got[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            $display("FAIL %s: got %0h expected %0h (32-bit chunk %0d)",
                     tag, got[k*32 +: 32], exp[k*32 +: 32], k);
        end
    endtask

    function automatic wide_t exp_row(input int r);
        wide_t v;
        logic [IN_W-1:0] w;
        v = '0;
        for (int x = 0; x < IMG_W; x++) begin
            w = fw[r*WPR + x/2];
            v[x*PIX_W +: PIX_W] = (x % 2 == 0) ? w[7:0] : w[15:8];
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_sum();
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < NWORDS; i++) s = s + fw[i];
        return s;
    endfunction

    task automatic drive(input logic v, input logic [IN_W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        we_cyc.delete(); we_addr.delete(); we_din.delete(); we_busy.delete();
        done_cyc.delete(); done_busy.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0000);
        drive(1'b0, 16'h0000);
        rst = 1'b0;
        clear_events();
    endtask

    // mode 0: back-to-back, 1: alternate valid/idle, 2: random idle gaps
    task automatic send_words(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, fw[i]);
            if (i % WPR == WPR - 1) row_edge[i/WPR] = cyc;
            if (i != n - 1) begin
                if (mode == 1) drive(1'b0, 16'($urandom));
                else if (mode == 2) repeat ($urandom_range(0, 3)) drive(1'b0, 16'($urandom));
            end
        end
    endtask

    // Idle during the last row write, a stray word in DONE, then idle
    task automatic send_tail();
        drive(1'b0, 16'($urandom));
        drive(1'b1, 16'hDEAD);
        repeat (3) drive(1'b0, 16'($urandom));
    endtask

    task automatic check_frame(input string tag, input int mode);
        int nw;
        check_val({tag, "_we_count"}, wide_t'(we_cyc.size()), wide_t'(IMG_H));
        nw = (we_cyc.size() < IMG_H) ? we_cyc.size() : IMG_H;
        for (int r = 0; r < nw; r++) begin
            check_val($sformatf("%s_addr%0d", tag, r), wide_t'(we_addr[r]), wide_t'(r));
            check_val($sformatf("%s_din%0d", tag, r), we_din[r], exp_row(r));
            check_val($sformatf("%s_we_time%0d", tag, r), wide_t'(we_cyc[r]), wide_t'(row_edge[r]));
            check_val($sformatf("%s_we_busy%0d", tag, r), wide_t'(we_busy[r]), wide_t'(1));
            if (r > 0 && mode < 2)
                check_val($sformatf("%s_we_gap%0d", tag, r), wide_t'(we_cyc[r] - we_cyc[r-1]),
                          wide_t'((mode == 0) ? WPR : 2*WPR));
        end
        check_val({tag, "_done_count"}, wide_t'(done_cyc.size()), wide_t'(1));
        if (done_cyc.size() > 0) begin
            check_val({tag, "_done_time"}, wide_t'(done_cyc[0]), wide_t'(row_edge[IMG_H-1] + 1));
            check_val({tag, "_done_busy"}, wide_t'(done_busy[0]), wide_t'(0));
        end
        check_val({tag, "_busy_end"}, wide_t'(busy), wide_t'(0));
        check_val({tag, "_addr_hold"}, wide_t'(img_addr), wide_t'(IMG_H - 1));
`ifdef LOADER_CHECKSUM_EN
        check_val({tag, "_checksum"}, wide_t'(checksum), wide_t'(exp_sum()));
`endif
    endtask

    initial begin
        logic [7:0] lo;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;

        // Reset and idle behaviour
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 16'($urandom));
            check_val("idle_we", wide_t'(img_we), wide_t'(0));
            check_val("idle_busy", wide_t'(busy), wide_t'(0));
            check_val("idle_done", wide_t'(done), wide_t'(0));
            check_val("idle_addr", wide_t'(img_addr), wide_t'(0));
        end
        check_val("idle_din", img_din, wide_t'(0));
`ifdef LOADER_CHECKSUM_EN
        check_val("idle_checksum", wide_t'(checksum), wide_t'(0));
`endif

        // Single row with an incrementing pixel pattern
        for (int k = 0; k < WPR; k++) begin
            lo    = 8'(k);
            fw[k] = {lo + 8'd1, lo};
        end
        clear_events();
        send_words(WPR, 0);
        check_val("row_busy", wide_t'(busy), wide_t'(1));
        repeat (3) drive(1'b0, 16'($urandom));
        check_val("row_we_count", wide_t'(we_cyc.size()), wide_t'(1));
        if (we_cyc.size() > 0) begin
            check_val("row_we_time", wide_t'(we_cyc[0]), wide_t'(row_edge[0]));
            check_val("row_addr", wide_t'(we_addr[0]), wide_t'(0));
            check_val("row_pix0", wide_t'(we_din[0][7:0]), wide_t'(8'h00));
            check_val("row_pix1", wide_t'(we_din[0][15:8]), wide_t'(8'h01));
            check_val("row_pix639", wide_t'(we_din[0][ROW_W-1 -: 8]), wide_t'(8'h40));
            check_val("row_din", we_din[0], exp_row(0));
        end
        check_val("row_no_done", wide_t'(done_cyc.size()), wide_t'(0));

        // Full frame back-to-back with random data
        do_reset();
        for (int i = 0; i < NWORDS; i++) fw[i] = 16'($urandom);
        send_words(NWORDS, 0);
        send_tail();
        check_frame("b2b", 0);

        // Same data with alternating valid: identical contents, twice the spacing
        clear_events();
        send_words(NWORDS, 1);
        send_tail();
        check_frame("toggle", 1);

        // Random gaps and new data
        clear_events();
        for (int i = 0; i < NWORDS; i++) fw[i] = 16'($urandom);
        send_words(NWORDS, 2);
        send_tail();
        check_frame("gaps", 2);

        // All-ones frame for the checksum wrap
        clear_events();
        for (int i = 0; i < NWORDS; i++) fw[i] = 16'hFFFF;
        send_words(NWORDS, 0);
        send_tail();
        check_frame("ones", 0);

        // Mid-frame reset after 500 words, then a fresh frame
        clear_events();
        for (int i = 0; i < NWORDS; i++) fw[i] = 16'($urandom);
        send_words(500, 0);
        do_reset();
        check_val("mrst_we", wide_t'(img_we), wide_t'(0));
        check_val("mrst_busy", wide_t'(busy), wide_t'(0));
        check_val("mrst_addr", wide_t'(img_addr), wide_t'(0));
        check_val("mrst_din", img_din, wide_t'(0));
        for (int i = 0; i < NWORDS; i++) fw[i] = 16'($urandom);
        send_words(NWORDS, 0);
        send_tail();
        check_frame("mrst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
